jtag_scan_sequencer: RTL and testbench
======================================

Name: jtag_scan_sequencer

Overview:
Host-side JTAG master that sequences a TAP controller. It accepts scan commands over a valid/ready interface and turns each into the TMS/TDI bit stream that walks the TAP state machine. Every command starts and ends with the TAP in Run-Test/Idle. For each scan it returns the TDO bits as a response word. It sits between the debug host logic and the JtagTap, driving tap_tms/tap_tdi and sampling tap_tdo.

Parameters:
MAX_LEN, 64, maximum scan length in bits; also the width of cmd_data and rsp_data.
LEN_W, 7, width of cmd_len; must satisfy 2**LEN_W > MAX_LEN.

Ports:
tck  input  1  clock; the same test clock the TAP consumes.
trst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command valid.
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
cmd_op  input  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=idle run.
cmd_len  input  LEN_W  scan length in bits (op 0/1) or Run-Test/Idle cycle count (op 3).
cmd_data  input  MAX_LEN  TDI bits, shifted LSB first.
rsp_valid  output  1  scan result valid.
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
rsp_data  output  MAX_LEN  captured TDO bits; bit i = i-th shifted bit.
tap_tms  output  1  registered TMS to the TAP.
tap_tdi  output  1  registered TDI to the TAP.
tap_tdo  input  1  TDO from the TAP.
busy  output  1  high whenever the block is not in IDLE.

Behaviour:
- Clock and reset: one clock, tck. trst is synchronous and active-high.
- Values while trst=1: tap_tms=1, tap_tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1, FSM=RST_SEQ.
- Output timing: tap_tms and tap_tdi are registered. A value driven in cycle k is consumed by the TAP at the next rising edge.
- FSM states: RST_SEQ, IDLE, HDR, SHIFT, EXIT, UPDATE, RUN, RSP.
- RST_SEQ: drive TMS=1 for 5 cycles, then TMS=0 for 1 cycle, then go to IDLE. After trst is released, cmd_ready first rises in cycle 7.
- IDLE: cmd_ready=1 and TMS=0. A handshake latches op, len and data.
- Length clamping: len > MAX_LEN is clamped to MAX_LEN.
- DR scan (op 0):
  - HDR drives TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - SHIFT drives len bits. TDI = data[i]. TMS=0 for bits 0..len-2 and TMS=1 on the last bit (Exit1).
  - UPDATE drives TMS=1, then TMS=0 back to Idle.
  - Total cycles from acceptance to return: len+5.
- IR scan (op 1): same as DR scan, but HDR drives TMS 1,1,0,0. Total len+6 cycles.
- TDO capture: rsp_data[i] = tap_tdo sampled on the edge at which the TAP consumes TDI bit i. Bits at and above len are 0.
- Scan with len=0 (op 0 or 1): no TAP activity. rsp_valid=1 the next cycle with rsp_data=0.
- TAP reset (op 2): 5×TMS=1 then TMS=0, back to IDLE. No response.
- Idle run (op 3): TMS=0 for len cycles (len=0 means none). No response; cmd_len is not clamped for op 3.
- RSP: rsp_valid=1, held stable until rsp_ready. TMS=0 holds the TAP in Idle. cmd_ready=0 while rsp_valid=1.
  - When rsp_ready is seen, rsp_valid drops next cycle and cmd_ready rises the same cycle.
- tap_tdi=0 outside SHIFT.
- cmd_data beyond len is ignored. Command fields are latched, so changes after acceptance have no effect.
- trst mid-command aborts: outputs return to their reset values, any pending response is dropped, and RST_SEQ restarts.
- No back-to-back overlap: the next command is accepted only from IDLE. Between commands there is at least 1 cycle with TMS=0.

Test Plan:
- Reset release → tap_tms = 1,1,1,1,1,0; cmd_ready=1 in cycle 7; a TAP model reports Test-Logic-Reset then Run-Test/Idle.
- IR scan, len=8, data=0x02 → tms = 1,1,0,0, 0×7, 1, 1, 0; tdi during SHIFT = 0,1,0,0,0,0,0,0; rsp_data = TAP model capture value 0x01; TAP model IR=0x02.
- DR scan, len=32, data=0, IDCODE selected in model (0x1BEEF0FF) → rsp_data=0x1BEEF0FF; busy high for 37 cycles.
- DR scan, len=70 → clamped to 64 shifts; rsp_data bits 63:0 valid; TMS=1 on shift bit 63.
- rsp_ready held low 10 cycles → rsp_valid and rsp_data stable, tap_tms=0, cmd_ready=0; cmd_ready rises the cycle rsp_ready is sampled.
- trst asserted at shift bit 5 of a DR scan → next cycle tap_tms=1 and rsp_valid=0; RST_SEQ repeats; no response is ever issued for the aborted scan.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// JTAG host-side scan sequencer: turns DR/IR scan, TAP-reset and idle-run commands
// into registered TMS/TDI streams, returning captured TDO bits for scans.
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tap_tms,
    output logic               tap_tdi,
    input  logic               tap_tdo,
    output logic               busy
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [1:0] OP_DR = 2'd0, OP_IR = 2'd1, OP_RST = 2'd2;

    typedef enum logic [2:0] {RST_SEQ, IDLE, HDR, SHIFT, EXIT, UPDATE, RUN, RSP} state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_rsp;
    logic               r_tms;
    logic               r_tdi;

    state_t             w_state_next;
    logic [LEN_W-1:0]   w_cnt_next;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [LEN_W-1:0]   w_len_eff;
    logic               w_ir_next;
    logic               w_tms_next;
    logic               w_tdi_next;

    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RSP);
    assign busy        = (r_state != IDLE);
    assign rsp_data    = r_rsp;
    assign tap_tms     = r_tms;
    assign tap_tdi     = r_tdi;
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    // Idle-run counts are cycle counts, not bit counts, so they bypass the clamp.
    assign w_len_eff   = (cmd_op == 2'd3) ? cmd_len : w_len_clamp;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            RST_SEQ: begin
                if (r_cnt == LEN_W'(5)) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    w_cnt_next = '0;
                    case (cmd_op)
                        OP_DR, OP_IR: w_state_next = (w_len_clamp == '0) ? RSP : HDR;
                        OP_RST:       w_state_next = RST_SEQ;
                        default:      w_state_next = (cmd_len == '0) ? IDLE : RUN;
                    endcase
                end
            end
            HDR: begin
                if (r_cnt == ((r_op == OP_IR) ? LEN_W'(3) : LEN_W'(2))) begin
                    w_cnt_next   = '0;
                    w_state_next = (r_len == LEN_W'(1)) ? EXIT : SHIFT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            SHIFT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == r_len - LEN_W'(2)) w_state_next = EXIT;
            end
            EXIT:   w_state_next = UPDATE;
            UPDATE: w_state_next = RSP;
            RUN: begin
                if (r_cnt == r_len - LEN_W'(1)) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RSP:     if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = RST_SEQ;
        endcase
    end

    // TMS/TDI are computed for the upcoming cycle so the pins come straight from flops.
    always_comb begin
        w_ir_next  = w_accept ? (cmd_op == OP_IR) : (r_op == OP_IR);
        w_tms_next = 1'b0;
        w_tdi_next = 1'b0;
        case (w_state_next)
            RST_SEQ: w_tms_next = (w_cnt_next < LEN_W'(5));
            HDR:     w_tms_next = (w_cnt_next < (w_ir_next ? LEN_W'(2) : LEN_W'(1)));
            SHIFT:   w_tdi_next = r_data[w_cnt_next[IDX_W-1:0]];
            EXIT: begin
                w_tms_next = 1'b1;
                w_tdi_next = r_data[w_cnt_next[IDX_W-1:0]];
            end
            UPDATE:  w_tms_next = 1'b1;
            default: w_tms_next = 1'b0;
        endcase
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            r_state <= RST_SEQ;
            r_cnt   <= '0;
            r_op    <= OP_DR;
            r_len   <= '0;
            r_data  <= '0;
            r_rsp   <= '0;
            r_tms   <= 1'b1;
            r_tdi   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tms   <= w_tms_next;
            r_tdi   <= w_tdi_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_len  <= w_len_eff;
                r_data <= cmd_data;
                r_rsp  <= '0;
            end
            // TDO is sampled on the same edge that consumes the matching TDI bit.
            if (r_state == SHIFT || r_state == EXIT) r_rsp[r_cnt[IDX_W-1:0]] <= tap_tdo;
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: TAP target model plus a per-cycle expected stream
// built from command-level rules, checked on every falling edge.
module tb_jtag_scan_sequencer;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;
    localparam logic [31:0] IDCODE = 32'h1BEEF0FF;

    logic tck = 1'b0;
    always #5 tck = ~tck;

    logic               trst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0]         cmd_op = 2'd0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               cmd_ready, rsp_valid, tap_tms, tap_tdi, tap_tdo, busy;
    logic [MAX_LEN-1:0] rsp_data;

    jtag_scan_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .tck(tck), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tap_tms(tap_tms), .tap_tdi(tap_tdi), .tap_tdo(tap_tdo), .busy(busy)
    );

    // ---------------- TAP target model (IR length 8, capture 0x01) ----------------
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t        tap_st = TLR;
    logic [7:0]  tap_ir = 8'hFF;
    logic [63:0] tap_sr = '0;
    int          tap_srlen = 1;
    int          tlr_visits = 0;
    assign tap_tdo = tap_sr[0];

    function automatic tap_t tap_next(tap_t s, logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDR  : PADR;
            PADR:  return tms ? EX2DR : PADR;
            EX2DR: return tms ? UPDR  : SHDR;
            UPDR:  return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPIR  : PAIR;
            PAIR:  return tms ? EX2IR : PAIR;
            EX2IR: return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            TLR: begin tap_ir <= 8'hFF; tlr_visits <= tlr_visits + 1; end
            CAPDR: begin
                if (tap_ir == 8'h02) begin tap_sr <= 64'(IDCODE); tap_srlen <= 32; end
                else begin tap_sr <= '0; tap_srlen <= 1; end
            end
            CAPIR: begin tap_sr <= 64'h01; tap_srlen <= 8; end
            SHDR, SHIR: tap_sr <= (tap_sr >> 1) | (64'(tap_tdi) << (tap_srlen - 1));
            UPIR: tap_ir <= tap_sr[7:0];
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tap_tms);
    end

    // ---------------- expected stream and checker ----------------
    typedef struct {
        logic tms; logic tdi; logic rdy; logic rv; logic bsy; logic chk; logic [63:0] rsp;
    } exp_t;
    exp_t expq[$];

    int n_cmp = 0, n_bad = 0, busy_cycles = 0;
    logic [63:0] last_rsp = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge tck) begin : cmp_blk
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("tap_tms", 64'(tap_tms), 64'(e.tms));
            chk("tap_tdi", 64'(tap_tdi), 64'(e.tdi));
            chk("cmd_ready", 64'(cmd_ready), 64'(e.rdy));
            chk("rsp_valid", 64'(rsp_valid), 64'(e.rv));
            chk("busy", 64'(busy), 64'(e.bsy));
            if (e.chk) chk("rsp_data", rsp_data, e.rsp);
            if (busy) busy_cycles++;
            if (rsp_valid) last_rsp = rsp_data;
        end
    end

    function automatic exp_t mk(logic tms, logic tdi, logic rdy, logic rv, logic bsy,
                                logic c, logic [63:0] r);
        exp_t e;
        e.tms = tms; e.tdi = tdi; e.rdy = rdy; e.rv = rv; e.bsy = bsy; e.chk = c; e.rsp = r;
        return e;
    endfunction

    // Scan result: the selected register's capture bits come out first, then TDI echoes.
    function automatic logic [63:0] exp_rsp(int reglen, logic [63:0] cap, logic [63:0] data, int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = (i < reglen) ? cap[i] : data[i - reglen];
        return r;
    endfunction

    task automatic add_rstseq(inout exp_t lst[$], input logic first_chk);
        for (int i = 0; i < 6; i++)
            lst.push_back(mk(i < 5, 1'b0, 1'b0, 1'b0, 1'b1, first_chk && i == 0, '0));
    endtask

    // Issues one command from an IDLE cycle and walks it cycle by cycle to the next IDLE.
    task automatic do_cmd(string tag, logic [1:0] op, int len, logic [63:0] data,
                          int reglen, logic [63:0] cap, int hold, int abort_at);
        exp_t lst[$];
        int   n;
        int   rsp_start = -1;
        logic [63:0] r;
        n = (op == 2'd3) ? len : ((len > MAX_LEN) ? MAX_LEN : len);
        lst.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0));
        if (op <= 2'd1) begin
            if (n > 0) begin
                lst.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
                if (op == 2'd1) lst.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
                lst.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
                lst.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
                for (int i = 0; i < n; i++)
                    lst.push_back(mk(i == n - 1, data[i], 1'b0, 1'b0, 1'b1, 1'b0, '0));
                lst.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
            end
            r = exp_rsp(reglen, cap, data, n);
            rsp_start = lst.size();
            for (int h = 0; h <= hold; h++) lst.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, r));
        end else if (op == 2'd2) begin
            add_rstseq(lst, 1'b0);
        end else begin
            for (int i = 0; i < n; i++) lst.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
        end
        lst.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0));
        if (abort_at >= 0) begin
            while (lst.size() > abort_at + 1) void'(lst.pop_back());
            add_rstseq(lst, 1'b1);
            lst.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0));
            rsp_start = -1;
        end
        cmd_op = op; cmd_len = LEN_W'(len); cmd_data = data; cmd_valid = 1'b1;
        foreach (lst[k]) expq.push_back(lst[k]);
        for (int j = 0; j < lst.size(); j++) begin
            rsp_ready = (rsp_start >= 0) && (j >= rsp_start + hold);
            trst = (j == abort_at);
            if (j > 0) begin
                cmd_valid = 1'b0;
                cmd_op    = 2'($urandom);
                cmd_len   = LEN_W'($urandom);
                cmd_data  = {$urandom, $urandom};
            end
            @(posedge tck); #1;
        end
        rsp_ready = 1'b0;
        chk({tag, "_drained"}, 64'(expq.size()), 64'd0);
        chk({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
        $display("cmd %s op=%0d len=%0d data=%h cycles=%0d rsp=%h", tag, op, len, data,
                 lst.size(), last_rsp);
    endtask

    int b0, t0;

    initial begin
        trst = 1'b1;
        repeat (2) @(posedge tck);
        #1;
        expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0));
        @(posedge tck); #1;
        trst = 1'b0;
        t0 = tlr_visits;
        begin : rst_blk
            exp_t lst[$];
            add_rstseq(lst, 1'b1);
            lst.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0));
            foreach (lst[k]) expq.push_back(lst[k]);
        end
        repeat (7) @(posedge tck);
        #1;
        chk("reset_drained", 64'(expq.size()), 64'd0);
        chk("reset_saw_tlr", 64'(tlr_visits > t0), 64'd1);
        chk("reset_tap_rti", 64'(tap_st), 64'(RTI));
        $display("reset release sequence done");

        do_cmd("ir_idcode", 2'd1, 8, 64'h02, 8, 64'h01, 0, -1);
        chk("ir_capture_lit", last_rsp, 64'h01);
        chk("tap_ir_lit", 64'(tap_ir), 64'h02);

        b0 = busy_cycles;
        do_cmd("dr_idcode", 2'd0, 32, 64'h0, 32, 64'(IDCODE), 0, -1);
        chk("idcode_lit", last_rsp, 64'h1BEEF0FF);
        chk("busy_cycles_lit", 64'(busy_cycles - b0), 64'd37);

        do_cmd("dr_clamp70", 2'd0, 70, 64'h0123_4567_89AB_CDEF, 32, 64'(IDCODE), 0, -1);
        chk("clamp_lit", last_rsp, 64'h89AB_CDEF_1BEE_F0FF);

        do_cmd("dr_hold10", 2'd0, 4, 64'h0, 32, 64'(IDCODE), 10, -1);
        chk("hold_lit", last_rsp, 64'hF);

        do_cmd("dr_abort", 2'd0, 16, 64'hFFFF, 32, 64'(IDCODE), 0, 9);
        chk("abort_tap_ir", 64'(tap_ir), 64'hFF);

        do_cmd("run70", 2'd3, 70, 64'h0, 0, 64'h0, 0, -1);
        do_cmd("run0", 2'd3, 0, 64'hFFFF, 0, 64'h0, 0, -1);
        do_cmd("scan_len0", 2'd0, 0, 64'hFFFF_FFFF, 0, 64'h0, 0, -1);
        do_cmd("tap_reset", 2'd2, 0, 64'h0, 0, 64'h0, 0, -1);
        do_cmd("dr_bypass", 2'd0, 8, 64'hFFFF_FF00_0000_00A5, 1, 64'h0, 0, -1);
        chk("bypass_lit", last_rsp, 64'h4A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
